// File: rtl/adder_pkg.sv
// Shared constants and types for the registered carry-lookahead adder.
// Imported by the adder top and its 4-bit lookahead blocks.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int CLA_BLOCK   = 4;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } adder_flags_t;

endpackage

// File: rtl/adder_32bit_cla_4bit.sv
// 4-bit carry-lookahead block: full lookahead on the internal carries,
// plus block propagate/generate for a future second lookahead level.
module cla_4bit
    import adder_pkg::*;
(
    input  logic [CLA_BLOCK-1:0] a,
    input  logic [CLA_BLOCK-1:0] b,
    input  logic                 ci,
    output logic [CLA_BLOCK-1:0] s,
    output logic                 co,
    output logic                 p_blk,
    output logic                 g_blk
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry expanded directly from ci, no internal ripple.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & ci);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);

    assign p_blk  = &w_p;
    assign g_blk  = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign w_c[4] = g_blk | (p_blk & ci);

    assign s  = w_p ^ w_c[3:0];
    assign co = w_c[4];

endmodule

// File: rtl/adder_32bit.sv
// Registered adder: ripple of 4-bit lookahead blocks, one-cycle latency,
// carry-out, signed overflow and zero flags captured with the sum.
module adder_32bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NBLK = WIDTH / CLA_BLOCK;
    localparam int MSB  = WIDTH - 1;

    logic [NBLK:0]    w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [NBLK-1:0]  w_unused_p;
    logic [NBLK-1:0]  w_unused_g;
    adder_flags_t     w_flags;

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    adder_flags_t     r_flags;

    assign w_carry[0] = cin;

    for (genvar gi = 0; gi < NBLK; gi++) begin : g_cla
        cla_4bit u_cla (
            .a     (a[gi*CLA_BLOCK +: CLA_BLOCK]),
            .b     (b[gi*CLA_BLOCK +: CLA_BLOCK]),
            .ci    (w_carry[gi]),
            .s     (w_sum[gi*CLA_BLOCK +: CLA_BLOCK]),
            .co    (w_carry[gi+1]),
            .p_blk (w_unused_p[gi]),
            .g_blk (w_unused_g[gi])
        );
    end

    assign w_flags.cout     = w_carry[NBLK];
    assign w_flags.overflow = (a[MSB] == b[MSB])
                           && (w_sum[MSB] != a[MSB]);
    assign w_flags.zero     = (w_sum == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_flags <= '0;
        end else begin
            r_valid <= in_valid;
            // Results hold while idle so inputs may be X then.
            if (in_valid) begin
                r_sum   <= w_sum;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign cout      = r_flags.cout;
    assign overflow  = r_flags.overflow;
    assign zero      = r_flags.zero;

endmodule

// File: tb/tb_adder_32bit.sv
// Scoreboard bench for adder_32bit: queued expectations, literal checks.
module tb_adder_32bit;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    int   n_checks;
    int   n_errors;
    exp_t q[$];
    exp_t last;

    adder_32bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x,
                                   input logic [31:0] y,
                                   input logic        c);
        exp_t        e;
        logic [32:0] f;
        longint      sv;
        f  = {1'b0, x} + {1'b0, y} + {32'd0, c};
        sv = longint'($signed(x)) + longint'($signed(y))
           + longint'(c);
        e.sum  = f[31:0];
        e.cout = f[32];
        e.ovf  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        e.zero = (f[31:0] == 32'd0);
        return e;
    endfunction

    task automatic issue(input logic [31:0] x,
                         input logic [31:0] y,
                         input logic        c);
        @(negedge clk);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        q.push_back(model(x, y, c));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_out(input string tag,
                              input logic [31:0] s,
                              input logic c,
                              input logic v,
                              input logic z);
        check({tag, "_sum"}, 64'(sum), 64'(s));
        check({tag, "_cout"}, 64'(cout), 64'(c));
        check({tag, "_ovf"}, 64'(overflow), 64'(v));
        check({tag, "_zero"}, 64'(zero), 64'(z));
    endtask

    // Monitor: pops one expectation per valid output, else expects hold.
    initial begin : monitor
        logic v;
        exp_t e;
        last = '0;
        forever begin
            @(posedge clk);
            v = in_valid && !rst;
            #1;
            if (rst) begin
                q.delete();
                last = '0;
                v    = 1'b0;
            end
            check("out_valid", 64'(out_valid), 64'(v));
            if (v) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: got output expected none");
                end else begin
                    e    = q.pop_front();
                    last = e;
                end
            end
            check("sb_sum", 64'(sum), 64'(last.sum));
            check("sb_cout", 64'(cout), 64'(last.cout));
            check("sb_ovf", 64'(overflow), 64'(last.ovf));
            check("sb_zero", 64'(zero), 64'(last.zero));
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(32'h0000_00F0, 32'h0000_0001, 1'b0);
        idle();
        expect_out("basic", 32'h0000_00F1, 1'b0, 1'b0, 1'b0);

        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        idle();
        expect_out("wrap", 32'h0, 1'b1, 1'b0, 1'b1);

        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0);
        expect_out("sovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        idle();
        expect_out("negovf", 32'h0, 1'b1, 1'b1, 1'b1);

        issue(32'h0FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'h1234_5678, 32'h1111_1111, 1'b1);
        expect_out("chain", 32'h1000_0000, 1'b0, 1'b0, 1'b0);
        idle();
        expect_out("b2b", 32'h2345_678A, 1'b0, 1'b0, 1'b0);

        issue(32'h5, 32'h3, 1'b0);
        idle();
        check("hold_v0", 64'(out_valid), 64'd1);
        check("hold_s0", 64'(sum), 64'h8);
        repeat (3) idle();
        check("hold_v", 64'(out_valid), 64'd0);
        check("hold_s", 64'(sum), 64'h8);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        issue(32'h9, 32'h9, 1'b0);
        idle();
        check("pre_rst_s", 64'(sum), 64'h12);
        #2;
        rst = 1'b1;
        #1;
        check("arst_v", 64'(out_valid), 64'd0);
        expect_out("arst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'h1, 32'h1, 1'b0);
        idle();
        check("post_rst_v", 64'(out_valid), 64'd1);
        check("post_rst_s", 64'(sum), 64'h2);
        idle();
        @(posedge clk);
        #2;
        check("sb_drain", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_32bit.md
Name: adder_32bit

Overview:
- Registered 32-bit two's-complement/unsigned adder with carry-in, carry-out and status flags.
- Core arithmetic datapath element of the 32-bit ALU; the ALU top and subtract path (b inverted, cin=1) feed it.
- Combinational carry-lookahead sum is captured in an output register.
- One-cycle latency with a simple valid pipeline.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum/flags valid
- sum  output  WIDTH  registered a+b+cin, low WIDTH bits
- cout  output  1  registered carry out of MSB (unsigned overflow)
- overflow  output  1  registered signed overflow
- zero  output  1  registered, 1 when sum==0

Behaviour:
- Reset: rst=1 asynchronously forces out_valid=0, sum=0, cout=0, overflow=0, zero=0, regardless of clk. Outputs hold these values while rst is high.
- Datapath: combinational {c_full, s_full} = a + b + cin, computed at WIDTH+1 bits. No truncation before carry extraction.
- Capture on each rising clk with rst=0 and in_valid=1:
  - sum <= s_full[WIDTH-1:0]
  - cout <= c_full
  - overflow <= (a[MSB]==b[MSB]) && (s_full[MSB]!=a[MSB])
  - zero <= (s_full[WIDTH-1:0]==0)
  - out_valid <= 1
- With in_valid=0 at the edge: out_valid <= 0, and sum/cout/overflow/zero hold their previous values.
- Latency: exactly 1 cycle, from the edge sampling in_valid=1 to the edge after which out_valid=1 and results are stable.
- Throughput: one result per cycle. Back-to-back in_valid is fully supported; no backpressure and no stall input.
- Carry structure: ripple of WIDTH/4 4-bit carry-lookahead blocks.
  - Each block computes generate g_i=a_i&b_i and propagate p_i=a_i^b_i.
  - Internal carries: c_{i+1}=g_i|p_i&c_i, expanded as lookahead within the block.
  - Block carry-out feeds the next block's carry-in. Block 0 carry-in is cin.
- Boundary cases:
  - 0xFFFFFFFF+0+cin=1 gives sum=0, cout=1, zero=1.
  - 0x7FFFFFFF+1 gives overflow=1, cout=0.
  - 0x80000000+0x80000000 gives sum=0, cout=1, overflow=1, zero=1.
- Reset mid-operation: an in-flight result is discarded. The first edge after rst deasserts behaves normally.
- X on inputs while in_valid=0 must not disturb held outputs.

Decomposition:
- Shared package adder_pkg:
  - constant ADDER_WIDTH=32
  - constant CLA_BLOCK=4
- One natural sub-module: cla_4bit.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, plus block P/G for optional future two-level lookahead.
  - Instantiated WIDTH/4 times via generate.
- Flag logic and output register stay in adder_32bit.

Test Plan:
- Basic add: a=0x000000F0, b=0x00000001, cin=0, in_valid=1 → next cycle sum=0x000000F1, cout=0, overflow=0, zero=0, out_valid=1.
- Unsigned wrap: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1, zero=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, overflow=1, cout=0. Then a=b=0x80000000 → sum=0, cout=1, overflow=1, zero=1.
- Carry across every CLA boundary: a=0x0FFFFFFF, b=0x00000001 → sum=0x10000000, cout=0. Back-to-back with a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A on the following cycle.
- Valid hold: issue 0x5+0x3 (sum=0x8), then in_valid=0 for 3 cycles with random a/b → out_valid=0 and sum stays 0x00000008.
- Async reset: assert rst between clock edges after a valid issue → outputs zero immediately with out_valid=0. Release rst, issue 0x1+0x1 → sum=0x2 one cycle later.
